iob_cmd_master: RTL



---
 rtl/iob_cmd_master.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/iob_cmd_master.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : iob_cmd_master
// Brief   : Command-stream to IOb Native manager with byte-lane alignment.
//           Optional watchdog abort: define IOB_CMD_MASTER_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module iob_cmd_master #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              cke_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_mode_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_data_i,
  input  logic [5:0]        cmd_width_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [1:0]        resp_mode_o,
  output logic [ADDR_W-1:0] resp_addr_o,
  output logic [DATA_W-1:0] resp_data_o,
  output logic              resp_err_o,
  output logic              done_o,
  output logic              iob_valid_o,
  output logic [ADDR_W-1:0] iob_addr_o,
  output logic [DATA_W-1:0] iob_wdata_o,
  output logic [3:0]        iob_wstrb_o,
  input  logic              iob_ready_i,
  input  logic              iob_rvalid_i,
  input  logic [DATA_W-1:0] iob_rdata_i
);

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_req    = 2'd1;
  localparam logic [1:0] c_st_rdwait = 2'd2;
  localparam logic [1:0] c_st_resp   = 2'd3;

  localparam logic [1:0] c_mode_rd  = 2'd0;
  localparam logic [1:0] c_mode_wr  = 2'd1;
  localparam logic [1:0] c_mode_fin = 2'd2;
  localparam logic [1:0] c_mode_rsv = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        w_state_next;
  logic [1:0]        r_mode;
  logic [ADDR_W-1:0] r_addr;
  logic [5:0]        r_width;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_wstrb;
  logic [DATA_W-1:0] r_resp_data;
  logic              r_err;
  logic              r_done;

  logic              w_cmd_fire;
  logic              w_abort;
  logic [5:0]        w_eff_w;
  logic [2:0]        w_nbytes;
  logic [3:0]        w_lanes;
  logic [3:0]        w_wstrb;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rmask;
  logic [DATA_W-1:0] w_rdata_ext;

  // Width 0 and anything above 32 both mean a full word.
  assign w_eff_w  = (cmd_width_i == 6'd0 || cmd_width_i > 6'd32) ? 6'd32 : cmd_width_i;
  assign w_nbytes = 3'((w_eff_w + 6'd7) >> 3);
  assign w_lanes  = 4'((5'd1 << w_nbytes) - 5'd1);
  assign w_wstrb  = w_lanes << cmd_addr_i[1:0];
  assign w_wdata  = cmd_data_i << {cmd_addr_i[1:0], 3'b000};

  assign w_rmask     = (r_width == 6'd32) ? '1 : ((32'd1 << r_width) - 32'd1);
  assign w_rdata_ext = (iob_rdata_i >> {r_addr[1:0], 3'b000}) & w_rmask;

  assign w_cmd_fire = cmd_valid_i && cmd_ready_o;

`ifdef IOB_CMD_MASTER_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] r_tmo;
  logic                 w_tmo_wait;

  assign w_tmo_wait = (r_state == c_st_req    && !iob_ready_i) ||
                      (r_state == c_st_rdwait && !iob_rvalid_i);
  // Abort on the edge where the counter would become all-ones.
  assign w_abort    = w_tmo_wait && (r_tmo == {{(TIMEOUT_W-1){1'b1}}, 1'b0});

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_tmo <= '0;
    end else if (cke_i) begin
      if (w_state_next != r_state) r_tmo <= '0;
      else                         r_tmo <= r_tmo + 1'b1;
    end
  end
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_W > 0);
  assign w_abort      = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_n_i)   r_state <= c_st_idle;
    else if (cke_i) r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_cmd_fire) begin
          case (cmd_mode_i)
            c_mode_rd, c_mode_wr: w_state_next = c_st_req;
            c_mode_rsv:           w_state_next = c_st_resp;
            default:              w_state_next = c_st_idle;
          endcase
        end
      end
      c_st_req: begin
        if (iob_ready_i) w_state_next = (r_mode == c_mode_wr) ? c_st_resp : c_st_rdwait;
        else if (w_abort) w_state_next = c_st_resp;
      end
      c_st_rdwait: begin
        if (iob_rvalid_i || w_abort) w_state_next = c_st_resp;
      end
      c_st_resp: begin
        if (resp_ready_i) w_state_next = c_st_idle;
      end
      default: w_state_next = c_st_idle;
    endcase
  end

  always_comb begin
    cmd_ready_o  = rst_n_i && (r_state == c_st_idle) && !r_done;
    iob_valid_o  = (r_state == c_st_req);
    resp_valid_o = (r_state == c_st_resp);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_mode      <= 2'd0;
      r_addr      <= '0;
      r_width     <= 6'd0;
      r_wdata     <= '0;
      r_wstrb     <= 4'd0;
      r_resp_data <= '0;
      r_err       <= 1'b0;
      r_done      <= 1'b0;
    end else if (cke_i) begin
      if (w_cmd_fire) begin
        r_mode      <= cmd_mode_i;
        r_addr      <= cmd_addr_i;
        r_width     <= w_eff_w;
        r_wdata     <= w_wdata;
        r_wstrb     <= (cmd_mode_i == c_mode_wr) ? w_wstrb : 4'd0;
        r_resp_data <= (cmd_mode_i == c_mode_wr) ? cmd_data_i : '0;
        r_err       <= (cmd_mode_i == c_mode_rsv);
        if (cmd_mode_i == c_mode_fin) r_done <= 1'b1;
      end else if (r_state == c_st_rdwait && iob_rvalid_i) begin
        r_resp_data <= w_rdata_ext;
      end else if (w_abort) begin
        r_err       <= 1'b1;
        r_resp_data <= '0;
      end
    end
  end

  assign resp_mode_o = r_mode;
  assign resp_addr_o = r_addr;
  assign resp_data_o = r_resp_data;
  assign resp_err_o  = r_err;
  assign done_o      = r_done;
  assign iob_addr_o  = r_addr;
  assign iob_wdata_o = r_wdata;
  assign iob_wstrb_o = r_wstrb;

endmodule
`default_nettype wire
